// File: rtl/usr_pkg.sv
// Shared mode encodings, FSM state type and mode classification for usr_burst.
package usr_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHR  = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_ROL  = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIN
   } state_t;

   // Modes that consume amount and run a multi-cycle burst; 111 is a second HOLD.
   function automatic logic is_shift(input logic [2:0] m);
      return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
             (m == MODE_ROL) || (m == MODE_ASR);
   endfunction

endpackage

// File: rtl/usr_step.sv
// One-position step of the universal shift register for the given mode.
module usr_step
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] cur,
   input  logic             left_in,
   input  logic             right_in,
   output logic [WIDTH-1:0] next
);

   always_comb begin
      next = cur;
      case (mode)
         MODE_SHR:             next = {right_in, cur[WIDTH-1:1]};
         MODE_SHL:             next = {cur[WIDTH-2:0], left_in};
         MODE_ROR:             next = {cur[0], cur[WIDTH-1:1]};
         MODE_ROL:             next = {cur[WIDTH-2:0], cur[WIDTH-1]};
         MODE_ASR:             next = {cur[WIDTH-1], cur[WIDTH-1:1]};
         MODE_HOLD, MODE_LOAD: next = cur;
         default:              next = cur;
      endcase
   end

endmodule

// File: rtl/usr_burst.sv
// Universal shift register running multi-position bursts with busy/done handshake.
module usr_burst
   import usr_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clc,
   input  logic             clear,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CNT_W-1:0] amount,
   input  logic             left_in,
   input  logic             right_in,
   input  logic [WIDTH-1:0] par_in,
   output logic [WIDTH-1:0] out,
   output logic             ser_out_r,
   output logic             ser_out_l,
   output logic             busy,
   output logic             done
);

   state_t           state, state_n;
   logic [CNT_W-1:0] count, count_n, amt_clamp;
   logic [2:0]       mode_q, mode_n;
   logic [WIDTH-1:0] out_n, step_next;

   assign amt_clamp = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;

   usr_step #(.WIDTH(WIDTH)) u_step (
      .mode     (mode_q),
      .cur      (out),
      .left_in  (left_in),
      .right_in (right_in),
      .next     (step_next)
   );

   always_ff @(posedge clc or negedge clear) begin
      if (!clear) begin
         state  <= S_IDLE;
         count  <= '0;
         mode_q <= MODE_HOLD;
         out    <= '0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         mode_q <= mode_n;
         out    <= out_n;
      end
   end

   always_comb begin
      state_n = state;
      count_n = count;
      mode_n  = mode_q;
      out_n   = out;
      case (state)
         S_IDLE: begin
            if (start) begin
               mode_n = mode;
               if (mode == MODE_LOAD) begin
                  out_n   = par_in;
                  state_n = S_FIN;
               end else if (is_shift(mode) && (amt_clamp != '0)) begin
                  count_n = amt_clamp;
                  state_n = S_RUN;
               end else begin
                  state_n = S_FIN;
               end
            end
         end
         S_RUN: begin
            // The final step is still applied on the edge that sees count==1.
            out_n   = step_next;
            count_n = count - CNT_W'(1);
            if (count == CNT_W'(1)) state_n = S_FIN;
         end
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   assign busy      = (state == S_RUN);
   assign done      = (state == S_FIN);
   assign ser_out_r = out[0];
   assign ser_out_l = out[WIDTH-1];

endmodule

// File: tb/tb_usr_burst.sv
// Randomized and directed checks of usr_burst (WIDTH=8) against a whole-burst reference model.
module tb_usr_burst;

   localparam int W = 8;

   logic       clc = 1'b0;
   logic       clear = 1'b0;
   logic       start = 1'b0;
   logic [2:0] mode = 3'b000;
   logic [3:0] amount = 4'd0;
   logic       left_in = 1'b0;
   logic       right_in = 1'b0;
   logic [7:0] par_in = 8'h00;
   logic [7:0] out;
   logic       ser_out_r, ser_out_l, busy, done;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [7:0]  cur_exp = 8'h00;

   usr_burst #(.WIDTH(W)) dut (
      .clc       (clc),
      .clear     (clear),
      .start     (start),
      .mode      (mode),
      .amount    (amount),
      .left_in   (left_in),
      .right_in  (right_in),
      .par_in    (par_in),
      .out       (out),
      .ser_out_r (ser_out_r),
      .ser_out_l (ser_out_l),
      .busy      (busy),
      .done      (done)
   );

   always #5 clc = ~clc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit shifting(input logic [2:0] m);
      return m inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
   endfunction

   // Whole-burst result: fill bit j is the serial input seen on step j.
   function automatic logic [7:0] model(input logic [2:0] m, input int n, input logic [7:0] v,
                                        input logic [7:0] p, input logic [7:0] lf, input logic [7:0] rf);
      logic [7:0]  res;
      int unsigned r;
      res = v;
      r   = n % W;
      case (m)
         3'b011: res = p;
         3'b001: begin
            res = v >> n;
            for (int j = 0; j < n; j++) res[W-n+j] = rf[j];
         end
         3'b010: begin
            res = v << n;
            for (int j = 0; j < n; j++) res[n-1-j] = lf[j];
         end
         3'b100: res = (v >> r) | (v << (W - r));
         3'b101: res = (v << r) | (v >> (W - r));
         3'b110: res = $signed(v) >>> n;
         default: res = v;
      endcase
      return res;
   endfunction

   task automatic do_op(input logic [2:0] m, input logic [3:0] a, input logic [7:0] p,
                        input logic [7:0] lf, input logic [7:0] rf, input bit noise);
      int n, n_eff;
      logic [7:0] exp_v;
      n     = (a > 4'd8) ? 8 : int'(a);
      n_eff = (shifting(m) && n > 0) ? n : 0;
      exp_v = model(m, shifting(m) ? n : 0, cur_exp, p, lf, rf);
      @(negedge clc);
      start = 1'b1; mode = m; amount = a; par_in = p;
      for (int k = 1; k <= n_eff + 1; k++) begin
         @(negedge clc);
         // Anything driven after acceptance, including a fresh start, must be ignored.
         start  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         mode   = 3'($urandom);
         amount = 4'($urandom);
         par_in = 8'($urandom);
         if (k <= n_eff) begin
            left_in  = lf[k-1];
            right_in = rf[k-1];
         end
         check("busy", 32'(busy), 32'(k <= n_eff));
         check("done", 32'(done), 32'(k == n_eff + 1));
         if (k == n_eff + 1) begin
            check("out", 32'(out), 32'(exp_v));
            check("ser_r", 32'(ser_out_r), 32'(exp_v[0]));
            check("ser_l", 32'(ser_out_l), 32'(exp_v[7]));
         end
      end
      start   = 1'b0;
      cur_exp = exp_v;
   endtask

   initial begin
      #3;
      check("rst_out", 32'(out), 32'h00);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(negedge clc);
      clear = 1'b1;

      do_op(3'b011, 4'd0, 8'hA5, 8'h00, 8'h00, 1'b0);
      check("load_a5", 32'(out), 32'hA5);
      do_op(3'b001, 4'd3, 8'h00, 8'h00, 8'hFF, 1'b0);
      check("shr3_f4", 32'(out), 32'hF4);
      do_op(3'b011, 4'd0, 8'h81, 8'h00, 8'h00, 1'b0);
      do_op(3'b101, 4'd1, 8'h00, 8'h00, 8'h00, 1'b0);
      check("rol1_03", 32'(out), 32'h03);
      do_op(3'b100, 4'd8, 8'h00, 8'h00, 8'h00, 1'b1);
      check("ror8_03", 32'(out), 32'h03);
      do_op(3'b011, 4'd0, 8'h90, 8'h00, 8'h00, 1'b0);
      do_op(3'b110, 4'd2, 8'h00, 8'h00, 8'h00, 1'b0);
      check("asr2_e4", 32'(out), 32'hE4);
      do_op(3'b110, 4'd15, 8'h00, 8'h00, 8'h00, 1'b1);
      check("asr15_ff", 32'(out), 32'hFF);
      do_op(3'b001, 4'd0, 8'h00, 8'h00, 8'h00, 1'b0);
      check("amt0_ff", 32'(out), 32'hFF);
      do_op(3'b010, 4'd8, 8'h00, 8'b01010101, 8'hFF, 1'b1);
      check("shl_toggle", 32'(out), 32'hAA);
      do_op(3'b001, 4'd12, 8'h00, 8'h00, 8'h3C, 1'b0);
      check("shr_full", 32'(out), 32'h3C);
      do_op(3'b111, 4'd5, 8'h77, 8'h00, 8'h00, 1'b0);
      check("hold111", 32'(out), 32'h3C);

      for (int i = 0; i < 60; i++)
         do_op(3'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);

      // Abort a burst with an asynchronous reset between edges.
      @(negedge clc);
      start = 1'b1; mode = 3'b001; amount = 4'd6;
      @(negedge clc);
      start = 1'b0;
      @(negedge clc);
      check("mid_busy", 32'(busy), 32'd1);
      #2 clear = 1'b0;
      #1;
      check("abort_out", 32'(out), 32'h00);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      cur_exp = 8'h00;
      @(negedge clc);
      clear = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clc);
         check("no_done", 32'(done), 32'd0);
      end
      do_op(3'b011, 4'd0, 8'h5A, 8'h00, 8'h00, 1'b0);
      check("post_load", 32'(out), 32'h5A);
      do_op(3'b100, 4'd4, 8'h00, 8'h00, 8'h00, 1'b0);
      check("post_ror4", 32'(out), 32'hA5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
